// File: rtl/regfile_scoreboard.sv
// Parametrised register file with write-to-read bypass and a per-register busy scoreboard.
// Decode reads operands and readiness combinationally; writeback ports write data and release busy marks.
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int N_REG    = 32,
  parameter int N_RD     = 3,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(N_REG)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_RD*AW-1:0]       raddr_i,
  output logic [N_RD*DATA_W-1:0]   rdata_o,
  output logic [N_RD-1:0]          rready_o,
  input  logic [1:0]               we_i,
  input  logic [2*AW-1:0]          waddr_i,
  input  logic [2*DATA_W-1:0]      wdata_i,
  input  logic [1:0]               wclr_i,
  input  logic                     iss_en_i,
  input  logic [AW-1:0]            iss_addr_i,
  output logic [AW:0]              busy_cnt_o,
  output logic                     sb_full_o
);

  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(N_REG - ZERO_REG);

  logic [DATA_W-1:0] regs_q [N_REG];
  logic [N_REG-1:0]  busy_q, busy_d;
  logic [AW:0]       cnt_q, cnt_d;

  logic [AW-1:0]     wAddr [2];
  logic [DATA_W-1:0] wData [2];
  logic [1:0]        wrEn;
  logic [1:0]        wrClr;
  logic [AW-1:0]     rAddr;
  logic [DATA_W-1:0] rVal;

  // Split the packed write buses; writes to the hardwired zero register are dropped here.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wAddr[p] = waddr_i[p*AW +: AW];
      wData[p] = wdata_i[p*DATA_W +: DATA_W];
      wrEn[p]  = we_i[p] && !((ZERO_REG != 0) && (wAddr[p] == '0));
      wrClr[p] = we_i[p] && wclr_i[p];
    end
  end

  // Port 1 is applied first so that port 0 overrides it on an address collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < N_REG; r++) regs_q[r] <= '0;
    end else begin
      if (wrEn[1]) regs_q[wAddr[1]] <= wData[1];
      if (wrEn[0]) regs_q[wAddr[0]] <= wData[0];
    end
  end

  // Issue is applied after the clears: the newer producer owns the register.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < 2; p++) begin
      if (wrClr[p]) busy_d[wAddr[p]] = 1'b0;
    end
    if (iss_en_i) busy_d[iss_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;

    cnt_d = cnt_q;
    for (int r = 0; r < N_REG; r++) begin
      if (busy_d[r] && !busy_q[r]) begin
        cnt_d = cnt_d + ONE;
      end else if (!busy_d[r] && busy_q[r]) begin
        cnt_d = cnt_d - ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read ports: zero register, then port 0 bypass, then port 1 bypass, then storage.
  always_comb begin
    rdata_o  = '0;
    rready_o = '0;
    rAddr    = '0;
    rVal     = '0;
    for (int i = 0; i < N_RD; i++) begin
      rAddr = raddr_i[i*AW +: AW];
      rVal  = regs_q[rAddr];
      if (we_i[1] && (wAddr[1] == rAddr)) rVal = wData[1];
      if (we_i[0] && (wAddr[0] == rAddr)) rVal = wData[0];
      if ((ZERO_REG != 0) && (rAddr == '0)) rVal = '0;
      rdata_o[i*DATA_W +: DATA_W] = rVal;
      rready_o[i] = !busy_q[rAddr]
                    || (wrClr[0] && (wAddr[0] == rAddr))
                    || (wrClr[1] && (wAddr[1] == rAddr));
    end
  end

  assign busy_cnt_o = cnt_q;
  assign sb_full_o  = (cnt_q == FULL_CNT);

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the 3-read/2-write register file: generic depth, width and read-port count, plus a per-register busy scoreboard.
- Sits in the decode/writeback stage. Decode reads operands and readiness in the same cycle and marks the destination busy at issue. Writeback ports write data and release the busy mark.
- Write-to-read bypass and a constant-zero register 0 are retained.

Parameters:
- DATA_W, 16, data width per register
- N_REG, 32, number of registers (power of two, >= 4); AW = $clog2(N_REG) is a local parameter
- N_RD, 3, number of combinational read ports (1..8)
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- raddr  in  N_RD*AW  read addresses, port i at bits [i*AW +: AW]
- rdata  out  N_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- rready  out  N_RD  1 = operand on port i is valid this cycle
- we  in  2  write enables for write ports 0 and 1
- waddr  in  2*AW  write addresses
- wdata  in  2*DATA_W  write data
- wclr  in  2  write port also clears the busy bit of waddr (qualified by we)
- iss_en  in  1  mark iss_addr busy
- iss_addr  in  AW  destination register being issued
- busy_cnt  out  AW+1  number of currently busy registers
- sb_full  out  1  high when busy_cnt equals N_REG-ZERO_REG

Behaviour:
- Reset (rst=1 at a clock edge):
  - all registers become 0, all busy bits become 0, busy_cnt becomes 0.
  - rst has priority over every other input in that cycle.
- Write, one-cycle latency: register waddr[p] takes wdata[p] at the edge where we[p]=1.
  - Both ports to the same address: port 0 wins; its wclr still applies.
  - ZERO_REG=1 and address 0: write is dropped.
- Read, combinational, same cycle:
  - Priority: address 0 with ZERO_REG=1 gives 0. Otherwise bypass from we[0]&&waddr[0]==raddr gives wdata[0]. Otherwise bypass from we[1]&&waddr[1]==raddr gives wdata[1]. Otherwise the stored value.
- rready[i]:
  - 1 if raddr[i] is not busy.
  - Also 1 if a write port with we&&wclr targets raddr[i] this cycle; bypassed data is then returned.
  - Otherwise 0.
  - rdata is still driven when rready=0; the consumer ignores it.
- Scoreboard update at each edge, per register r:
  - set = iss_en && iss_addr==r && !(ZERO_REG && r==0)
  - clr = any port p with we[p]&&wclr[p]&&waddr[p]==r
  - next busy = set ? 1 : (clr ? 0 : busy). Set wins over a same-cycle clear, because the newer producer owns the register.
  - Set on an already-busy register: stays busy, no count change.
  - Clear on a non-busy register: no effect.
- busy_cnt is registered and tracks the population of busy bits exactly; it never wraps. Increment/decrement is the net of set/clear transitions, including two clears in one cycle (−2) and set plus clear on different registers (net 0).
- sb_full is combinational from busy_cnt.
- Issuing to a busy register while sb_full is legal and does not change the count.
- iss_en to register 0 with ZERO_REG=1 is ignored.
- Reads depend only on the current-cycle iss_en: a register issued this cycle reads not-busy until the next edge.

Test Plan:
- Reset, then read r5 on all ports -> rdata=0x0000, rready=1, busy_cnt=0.
- Cycle 1: we[0]=1, waddr=3, wdata=0xBEEF, raddr[0]=3 -> rdata[0]=0xBEEF the same cycle. Next cycle, no write -> rdata[0]=0xBEEF from storage.
- Issue r7.
  - Next cycle raddr[1]=7 -> rready[1]=0, busy_cnt=1.
  - Then we[1]=1, wclr[1]=1, waddr=7, wdata=0x1234 -> rready[1]=1 and rdata[1]=0x1234 that cycle; busy_cnt=0 after the edge.
- Both ports write r9 (port 0 0x1111, port 1 0x2222) -> r9=0x1111. Write 0xFFFF to r0 and issue r0 -> r0 reads 0, busy_cnt unchanged.
- r4 busy; same cycle iss_en r4 and wclr write to r4 -> r4 stays busy, busy_cnt unchanged. Two wclr writes to busy r2 and r6 in one cycle -> busy_cnt decreases by 2.
- Issue r1..r31 on consecutive cycles -> busy_cnt=31, sb_full=1.
  - Assert rst mid-sequence -> next cycle all rready=1, busy_cnt=0, r3 reads 0.
